// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - single-clock FIFO controller with level flags and sticky errors
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.

module sync_fifo_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_SIZE  = 3,
   parameter int BUF_SIZE   = 8,
   parameter int AF_LEVEL   = 6,
   parameter int AE_LEVEL   = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  wen,
   input  logic [DATA_WIDTH-1:0] data_w,
   input  logic                  ren,
   output logic [DATA_WIDTH-1:0] data_r,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_SIZE:0]    count,
   output logic                  overflow,
   output logic                  underflow
);
   localparam logic [ADDR_SIZE:0] AF_L = AF_LEVEL[ADDR_SIZE:0];
   localparam logic [ADDR_SIZE:0] AE_L = AE_LEVEL[ADDR_SIZE:0];

   logic [DATA_WIDTH-1:0] mem_q [BUF_SIZE];
   logic [ADDR_SIZE:0]    wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
   logic                  overflow_q, overflow_d, underflow_q, underflow_d;
   logic                  wr_acc, rd_acc;

   // Pointers carry one extra wrap bit so full and empty are distinguishable
   assign full  = (wptr_q[ADDR_SIZE] != rptr_q[ADDR_SIZE]) &&
                  (wptr_q[ADDR_SIZE-1:0] == rptr_q[ADDR_SIZE-1:0]);
   assign empty = (wptr_q == rptr_q);
   assign almost_full  = (count_q >= AF_L);
   assign almost_empty = (count_q <= AE_L);
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

   assign wr_acc = wen & ~full & ~clr;
   assign rd_acc = ren & ~empty & ~clr;

   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q | (wen & full);
      underflow_d = underflow_q | (ren & empty);
      if (clr) begin
         wptr_d      = '0;
         rptr_d      = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (wr_acc) wptr_d = wptr_q + 1'b1;
         if (rd_acc) rptr_d = rptr_q + 1'b1;
         case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wptr_q[ADDR_SIZE-1:0]] <= data_w;
   end

`ifdef SYNC_FIFO_FWFT_EN
   // Head word is shown directly; forced to zero while empty so reset reads back 0
   assign data_r = empty ? '0 : mem_q[rptr_q[ADDR_SIZE-1:0]];
`else
   logic [DATA_WIDTH-1:0] data_r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      data_r_q <= '0;
      else if (rd_acc) data_r_q <= mem_q[rptr_q[ADDR_SIZE-1:0]];
   end

   assign data_r = data_r_q;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb/tb_sync_fifo_ctrl.sv - self-checking bench for sync_fifo_ctrl
// Vector table plus queue-based reference model; honours SYNC_FIFO_FWFT_EN.

module tb_sync_fifo_ctrl;
   localparam int DW = 32;
   localparam int AS = 3;
   localparam int BS = 8;
   localparam int AF = 6;
   localparam int AE = 2;

   logic          clk = 1'b0;
   logic          rst_n, clr, wen, ren;
   logic [DW-1:0] data_w, data_r;
   logic          full, empty, almost_full, almost_empty;
   logic [AS:0]   count;
   logic          overflow, underflow;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   sync_fifo_ctrl #(
      .DATA_WIDTH(DW), .ADDR_SIZE(AS), .BUF_SIZE(BS), .AF_LEVEL(AF), .AE_LEVEL(AE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .wen(wen), .data_w(data_w), .ren(ren),
      .data_r(data_r), .full(full), .empty(empty), .almost_full(almost_full),
      .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
   );

   // Reference model: an ordered queue of stored words plus sticky flags
   logic [DW-1:0] mq[$];
   bit            m_ov, m_un;
   logic [DW-1:0] m_dr;

   typedef struct {
      logic        c, w, r;
      logic [31:0] d;
      int          cnt;
      logic        f, e, af, ae, ov, un;
      logic [31:0] dr;
   } vec_t;

   vec_t tbl [19];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic model_reset();
      mq.delete();
      m_ov = 0;
      m_un = 0;
      m_dr = '0;
   endtask

   task automatic check_model();
      check("count", 32'(count), 32'(mq.size()));
      check("full", 32'(full), 32'(mq.size() == BS));
      check("empty", 32'(empty), 32'(mq.size() == 0));
      check("almost_full", 32'(almost_full), 32'(mq.size() >= AF));
      check("almost_empty", 32'(almost_empty), 32'(mq.size() <= AE));
      check("overflow", 32'(overflow), 32'(m_ov));
      check("underflow", 32'(underflow), 32'(m_un));
`ifdef SYNC_FIFO_FWFT_EN
      if (mq.size() > 0) check("data_r", data_r, mq[0]);
`else
      check("data_r", data_r, m_dr);
`endif
   endtask

   task automatic cyc(input logic c, input logic w, input logic r, input logic [DW-1:0] d);
      bit was_full, was_empty;
      clr = c; wen = w; ren = r; data_w = d;
      @(posedge clk);
      was_full  = (mq.size() == BS);
      was_empty = (mq.size() == 0);
      if (c) begin
         mq.delete();
         m_ov = 0;
         m_un = 0;
      end else begin
         if (r && !was_empty) m_dr = mq.pop_front();
         if (w && !was_full)  mq.push_back(d);
         if (w && was_full)   m_ov = 1;
         if (r && was_empty)  m_un = 1;
      end
      #1;
      check_model();
   endtask

   initial begin
      for (int i = 0; i < 8; i++)
         tbl[i] = '{1'b0, 1'b1, 1'b0, 32'h11 * (i + 1), i + 1, (i == 7), 1'b0,
                    (i + 1 >= 6), (i + 1 <= 2), 1'b0, 1'b0, 32'h0};
      tbl[8] = '{1'b0, 1'b1, 1'b0, 32'h99, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
      for (int i = 0; i < 8; i++)
         tbl[9 + i] = '{1'b0, 1'b0, 1'b1, 32'h0, 7 - i, 1'b0, (i == 7), (7 - i >= 6),
                        (7 - i <= 2), 1'b1, 1'b0, 32'h11 * (i + 1)};
      tbl[17] = '{1'b0, 1'b0, 1'b1, 32'h0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h88};
      tbl[18] = '{1'b1, 1'b0, 1'b0, 32'h0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h88};

      rst_n = 1'b0; clr = 0; wen = 0; ren = 0; data_w = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_count", 32'(count), 0);
      check("rst_empty", 32'(empty), 1);
      check("rst_full", 32'(full), 0);
      check("rst_ae", 32'(almost_empty), 1);
      check("rst_af", 32'(almost_full), 0);
      check("rst_data_r", data_r, 0);
      #2 rst_n = 1'b1;

      for (int i = 0; i < 19; i++) begin
         cyc(tbl[i].c, tbl[i].w, tbl[i].r, tbl[i].d);
         check($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
         check($sformatf("tbl%0d_full", i), 32'(full), 32'(tbl[i].f));
         check($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].e));
         check($sformatf("tbl%0d_af", i), 32'(almost_full), 32'(tbl[i].af));
         check($sformatf("tbl%0d_ae", i), 32'(almost_empty), 32'(tbl[i].ae));
         check($sformatf("tbl%0d_ov", i), 32'(overflow), 32'(tbl[i].ov));
         check($sformatf("tbl%0d_un", i), 32'(underflow), 32'(tbl[i].un));
`ifndef SYNC_FIFO_FWFT_EN
         check($sformatf("tbl%0d_data_r", i), data_r, tbl[i].dr);
`endif
      end

      // Simultaneous access while full, then while empty
      for (int i = 0; i < BS; i++) cyc(0, 1, 0, 32'hC0 + i);
      cyc(0, 1, 1, 32'hDEAD);
      check("full_rw_count", 32'(count), 7);
      check("full_rw_ov", 32'(overflow), 1);
      for (int i = 0; i < 7; i++) cyc(0, 0, 1, '0);
      cyc(0, 1, 1, 32'hBEEF);
      check("empty_rw_count", 32'(count), 1);
      check("empty_rw_un", 32'(underflow), 1);

      // Steady occupancy of 4 through several pointer wraps
      cyc(1, 0, 0, '0);
      for (int i = 0; i < 4; i++) cyc(0, 1, 0, 32'h100 + i);
      for (int i = 4; i < 28; i++) cyc(0, 1, 1, 32'h100 + i);
      check("wrap_count", 32'(count), 4);
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, '0);
`ifndef SYNC_FIFO_FWFT_EN
      check("wrap_last", data_r, 32'h100 + 27);
`endif

      // Asynchronous reset mid-stream, observed before the next edge
      for (int i = 0; i < 5; i++) cyc(0, 1, 0, 32'h200 + i);
      #2 rst_n = 1'b0;
      #1;
      check("arst_count", 32'(count), 0);
      check("arst_empty", 32'(empty), 1);
      check("arst_data_r", data_r, 0);
      model_reset();
      #1 rst_n = 1'b1;
      cyc(0, 1, 0, 32'hA5);
`ifdef SYNC_FIFO_FWFT_EN
      check("fwft_a5", data_r, 32'hA5);
`else
      cyc(0, 0, 1, '0);
      check("read_a5", data_r, 32'hA5);
`endif

      // Randomised traffic against the model
      for (int i = 0; i < 600; i++) begin
         int mode = i / 150;
         logic w = ($urandom_range(0, 99) < (mode == 1 ? 80 : (mode == 2 ? 25 : 55)));
         logic r = ($urandom_range(0, 99) < (mode == 1 ? 25 : (mode == 2 ? 80 : 50)));
         logic c = ($urandom_range(0, 63) == 0);
         cyc(c, w, r, $urandom);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
